// File: rtl/maxpool_2x2_engine_pkg.sv
// Purpose: shared sizing, bus widths and FSM encoding for the 2x2 stride-2 max-pool engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxpool_2x2_engine_pkg;

    localparam int DATA_W   = 8;
    localparam int IN_H     = 6;
    localparam int IN_W     = 6;
    localparam int CH       = 3;
    localparam int POOL_K   = 2;
    localparam int OUT_H    = IN_H / POOL_K;
    localparam int OUT_W    = IN_W / POOL_K;
    localparam int IN_BITS  = IN_H * IN_W * CH * DATA_W;
    localparam int OUT_BITS = OUT_H * OUT_W * CH * DATA_W;
    localparam int N_WIN    = OUT_H * OUT_W * CH;
    localparam int CNT_W    = $clog2(N_WIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of input element (c,r,x) inside the flat input map.
    function automatic int in_off(input int c, input int r, input int x);
        return ((c * IN_H + r) * IN_W + x) * DATA_W;
    endfunction

endpackage

// File: rtl/maxpool_2x2_engine_if.sv
// Purpose: map-in / pooled-map-out bus between the conv stage and the pooling engine.
// Latency: n/a (wiring only).
// Backpressure: level valids; producer holds in_vld until out_vld is seen.
interface maxpool_2x2_engine_if;
    import maxpool_2x2_engine_pkg::*;

    logic                in_vld;
    logic [IN_BITS-1:0]  conv_lin;
    logic [OUT_BITS-1:0] pool_lin;
    logic                out_vld;

    modport master (output in_vld, output conv_lin, input pool_lin, input out_vld);
    modport slave  (input in_vld, input conv_lin, output pool_lin, output out_vld);

endinterface

// File: rtl/maxpool_2x2_engine_max4_s8.sv
// Purpose: signed maximum of four elements as two pair compares feeding a final compare.
// Latency: combinational.
// Backpressure: none.
module max4_s8
    import maxpool_2x2_engine_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] y
);

    logic signed [DATA_W-1:0] max_ab;
    logic signed [DATA_W-1:0] max_cd;

    assign max_ab = (a > b) ? a : b;
    assign max_cd = (c > d) ? c : d;
    assign y      = (max_ab > max_cd) ? max_ab : max_cd;

endmodule

// File: rtl/maxpool_2x2_engine.sv
// Purpose: 2x2 stride-2 max-pool of a captured CHxIN_HxIN_W map, one window per clock.
// Latency: out_vld rises N_WIN edges after the capture edge; falls one edge after in_vld drops.
// Backpressure: none; in_vld ignored while computing, result held until in_vld is released.
module maxpool_2x2_engine
    import maxpool_2x2_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    maxpool_2x2_engine_if.slave  bus
);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IN_BITS-1:0]       cap_q;
    logic [OUT_BITS-1:0]      pool_q;
    logic                     out_vld_q, out_vld_d;
    logic                     cap_en, win_wr;
    int                       win_c, win_r, win_x;
    logic signed [DATA_W-1:0] e00, e01, e10, e11, win_max;

    // Window index k = c*OUT_H*OUT_W + r*OUT_W + x, which is also its output slot.
    always_comb begin
        win_c = int'(cnt_q) / (OUT_H * OUT_W);
        win_r = (int'(cnt_q) % (OUT_H * OUT_W)) / OUT_W;
        win_x = int'(cnt_q) % OUT_W;
        e00   = cap_q[in_off(win_c, 2 * win_r,     2 * win_x)     +: DATA_W];
        e01   = cap_q[in_off(win_c, 2 * win_r,     2 * win_x + 1) +: DATA_W];
        e10   = cap_q[in_off(win_c, 2 * win_r + 1, 2 * win_x)     +: DATA_W];
        e11   = cap_q[in_off(win_c, 2 * win_r + 1, 2 * win_x + 1) +: DATA_W];
    end

    max4_s8 u_max4 (
        .a (e00),
        .b (e01),
        .c (e10),
        .d (e11),
        .y (win_max)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        cap_en    = 1'b0;
        win_wr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_vld) begin
                    cap_en  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                win_wr = 1'b1;
                if (cnt_q == CNT_W'(N_WIN - 1)) begin
                    cnt_d     = '0;
                    out_vld_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!bus.in_vld) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                out_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            cap_q     <= '0;
            pool_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            if (cap_en) begin
                cap_q <= bus.conv_lin;
            end
            if (win_wr) begin
                pool_q[int'(cnt_q) * DATA_W +: DATA_W] <= win_max;
            end
        end
    end

    assign bus.pool_lin = pool_q;
    assign bus.out_vld  = out_vld_q;

endmodule

// File: tb/tb_maxpool_2x2_engine.sv
// Bench for maxpool_2x2_engine: directed maps plus random maps scored against a plain max-pool model.
module tb_maxpool_2x2_engine;
    import maxpool_2x2_engine_pkg::*;

    localparam int OB = OUT_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maxpool_2x2_engine_if bus_if();

    maxpool_2x2_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [OB-1:0] got, input logic [OB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [7:0] el(input logic [IN_BITS-1:0] m, input int c, input int r, input int x);
        return m[in_off(c, r, x) +: 8];
    endfunction

    // Reference: for each output cell scan its 2x2 block and keep the largest signed value.
    function automatic logic [OB-1:0] ref_pool(input logic [IN_BITS-1:0] m);
        logic [OB-1:0]    o;
        logic signed [7:0] best, v;
        o = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT_H; r++)
                for (int x = 0; x < OUT_W; x++) begin
                    best = el(m, c, 2 * r, 2 * x);
                    for (int dr = 0; dr < 2; dr++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = el(m, c, 2 * r + dr, 2 * x + dx);
                            if (v > best) best = v;
                        end
                    o[((c * OUT_H + r) * OUT_W + x) * 8 +: 8] = best;
                end
        return o;
    endfunction

    function automatic logic [IN_BITS-1:0] rand_map();
        logic [IN_BITS-1:0] m;
        for (int i = 0; i < IN_BITS / 32; i++) m[i * 32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [IN_BITS-1:0] fill_map(input logic [7:0] v);
        logic [IN_BITS-1:0] m;
        for (int i = 0; i < IN_BITS / 8; i++) m[i * 8 +: 8] = v;
        return m;
    endfunction

    // One full transaction: present, time the result, optionally hold in_vld, release, check drop and retention.
    task automatic run_map(input logic [IN_BITS-1:0] map, input bit toggle, input int hold,
                           input string tag, output logic [OB-1:0] res);
        logic [OB-1:0] exp;
        int n;
        exp = ref_pool(map);
        @(negedge clk);
        rst_n           = 1'b1;
        bus_if.conv_lin = map;
        bus_if.in_vld   = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (toggle) bus_if.conv_lin = rand_map();
        end while (!bus_if.out_vld && n < 40);
        chk({tag, "_lat"}, OB'(n), OB'(27));
        chk({tag, "_res"}, bus_if.pool_lin, exp);
        res = bus_if.pool_lin;
        if (hold > 0) begin
            bus_if.conv_lin = rand_map();
            repeat (hold) @(posedge clk);
            #1;
            chk({tag, "_hold_vld"}, OB'(bus_if.out_vld), OB'(1));
            chk({tag, "_hold_res"}, bus_if.pool_lin, exp);
        end
        @(negedge clk);
        bus_if.in_vld = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, OB'(bus_if.out_vld), OB'(0));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_retain"}, bus_if.pool_lin, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [IN_BITS-1:0] m;
        logic [OB-1:0]      res, kexp;

        m = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IN_H; r++)
                for (int x = 0; x < IN_W; x++)
                    m[in_off(c, r, x) +: 8] = 8'(c * 36 + r * 6 + x);

        // Reset held with in_vld high: nothing may start.
        bus_if.in_vld   = 1'b1;
        bus_if.conv_lin = m;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_vld", OB'(bus_if.out_vld), OB'(0));
            chk("rst_pool", bus_if.pool_lin, '0);
        end

        // Known ramp map; expected values from the closed-form bottom-right-of-block rule.
        run_map(m, 1'b0, 0, "known", res);
        kexp = '0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OUT_H; r++)
                for (int x = 0; x < OUT_W; x++)
                    kexp[((c * OUT_H + r) * OUT_W + x) * 8 +: 8] = 8'(c * 36 + (2 * r + 1) * 6 + 2 * x + 1);
        chk("known_formula", res, kexp);
        chk("known_p000", OB'(res[7:0]), OB'(7));
        chk("known_p222", OB'(res[OB-1 -: 8]), OB'(107));

        // Signed compares on two hand-built windows.
        m = '0;
        m[in_off(0, 0, 0) +: 8] = 8'h80;
        m[in_off(0, 0, 1) +: 8] = 8'hFF;
        m[in_off(0, 1, 0) +: 8] = 8'h7F;
        m[in_off(0, 1, 1) +: 8] = 8'h00;
        m[in_off(0, 0, 2) +: 8] = 8'h80;
        m[in_off(0, 0, 3) +: 8] = 8'h81;
        m[in_off(0, 1, 2) +: 8] = 8'hFE;
        m[in_off(0, 1, 3) +: 8] = 8'hFF;
        run_map(m, 1'b0, 0, "signed", res);
        chk("signed_w0", OB'(res[7:0]), OB'(8'h7F));
        chk("signed_w1", OB'(res[15:8]), OB'(8'hFF));

        run_map(fill_map(8'h80), 1'b0, 0, "all80", res);
        chk("all80_const", res, {(OB / 8){8'h80}});

        // Each window position in turn holds the only nonzero value.
        for (int p = 0; p < 4; p++) begin
            run_map('0, 1'b0, 0, "clear", res);
            m = '0;
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < OUT_H; r++)
                    for (int x = 0; x < OUT_W; x++)
                        m[in_off(c, 2 * r + p / 2, 2 * x + p % 2) +: 8] = 8'h55;
            run_map(m, 1'b0, 0, "pos", res);
            chk("pos_const", res, {(OB / 8){8'h55}});
        end

        // Continuous in_vld: result held, no recompute despite new input data.
        run_map(rand_map(), 1'b0, 6, "hold", res);

        // Input bus churns while computing; result must follow the captured map.
        run_map(rand_map(), 1'b1, 0, "toggle", res);

        // Reset part-way through: immediate clear, then a clean rerun.
        @(negedge clk);
        bus_if.conv_lin = rand_map();
        bus_if.in_vld   = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b0;
        bus_if.in_vld = 1'b0;
        #1;
        chk("midrst_vld", OB'(bus_if.out_vld), OB'(0));
        chk("midrst_pool", bus_if.pool_lin, '0);
        run_map(rand_map(), 1'b0, 0, "after_rst", res);

        for (int i = 0; i < 100; i++) begin
            run_map(rand_map(), 1'b0, 0, "rand", res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
